cloud_sprite_render: RTL and testbench

- Consumer side of the cloud position interface: takes the cloud object position (upper-right-corner reference) and the VGA scan coordinates, and decides per pixel whether the cloud is drawn.
- Latches the position once per frame so a moving cloud never tears mid-frame.
- Feeds the pixel mux alongside the dino and cactus renderers.
- Two-stage pipeline advanced by the pixel strobe.

---
 rtl/dino_pkg.sv | 18 +
 rtl/cloud_shape.sv | 36 +++
 rtl/cloud_sprite_render.sv | 126 ++++++++++++
 tb/tb_cloud_sprite_render.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared constants for the dino game renderers and object movers.
package dino_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned CLOUD_W  = 80;
  localparam int unsigned CLOUD_H  = 30;

  // 3-3-2 colours
  localparam logic [7:0] COL_WHITE = 8'hFF;
  localparam logic [7:0] COL_SHADE = 8'hB6;
  localparam logic [7:0] COL_BLACK = 8'h00;

  // Cloud reset position (upper-right reference): just off the right edge
  localparam logic [9:0] CLOUD_RST_H = 10'(SCREEN_W + CLOUD_W);
  localparam logic [9:0] CLOUD_RST_V = 10'(200 - CLOUD_H);

endpackage

// File: rtl/cloud_shape.sv
// Combinational cloud shape mask from cloud-local coordinates.
// Optional macro: CLOUD_SHADOW_EN adds the shade flag output.
// Ports:
//   i_lx      cloud-local column (0..79)
//   i_ly      cloud-local row (0..29)
//   o_mask_c  pixel belongs to the cloud body
//   o_shade_c pixel lies in the shaded underside (CLOUD_SHADOW_EN only)
module cloud_shape
  import dino_pkg::*;
(
  input  logic [6:0] i_lx,
  input  logic [4:0] i_ly,
  output logic       o_mask_c
`ifdef CLOUD_SHADOW_EN
  ,
  output logic       o_shade_c
`endif
);

  logic w_in_box;
  logic w_top_band;
  logic w_corner;

  assign w_in_box   = (i_lx < 7'(CLOUD_W)) && (i_ly < 5'(CLOUD_H));
  // Narrow puff on top of the body
  assign w_top_band = (i_lx >= 7'd20) && (i_lx < 7'd60);
  // Rounded bottom corners
  assign w_corner   = (i_ly >= 5'd26) && ((i_lx < 7'd4) || (i_lx >= 7'd76));

  assign o_mask_c = w_in_box && ((i_ly < 5'd10) ? w_top_band : !w_corner);

`ifdef CLOUD_SHADOW_EN
  assign o_shade_c = w_in_box && (i_ly >= 5'd24);
`endif

endmodule

// File: rtl/cloud_sprite_render.sv
// Cloud sprite renderer: per-frame position latch plus a two-stage
// pixel pipeline (box test, then shape mask) advanced by pix_en.
// Optional macro: CLOUD_SHADOW_EN (shaded underside, cloud_shade output).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pix_en          pixel strobe; pipeline advances only when high
//   frame_start     capture cloud_h/cloud_v for the next frame
//   de, hc, vc      scan position and display enable
//   cloud_h/cloud_v cloud upper-right corner
//   cloud_on        cloud covers the pixel (2 strobes after hc/vc)
//   cloud_rgb       cloud colour or 0
//   cloud_shade     shaded underside pixel (CLOUD_SHADOW_EN only)
module cloud_sprite_render #(
  parameter int unsigned CLOUD_W   = dino_pkg::CLOUD_W,
  parameter int unsigned CLOUD_H   = dino_pkg::CLOUD_H,
  parameter int unsigned SCREEN_W  = dino_pkg::SCREEN_W,
  parameter logic [7:0]  CLOUD_RGB = dino_pkg::COL_WHITE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       frame_start,
  input  logic       de,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic [9:0] cloud_h,
  input  logic [9:0] cloud_v,
  output logic       cloud_on,
  output logic [7:0] cloud_rgb
`ifdef CLOUD_SHADOW_EN
  ,
  output logic       cloud_shade
`endif
);

  logic [9:0]        r_h_lat;
  logic [9:0]        r_v_lat;
  logic              r_hit1;
  logic [6:0]        r_lx;
  logic [4:0]        r_ly;

  logic signed [10:0] w_x_left;
  logic signed [10:0] w_lx;
  logic signed [10:0] w_ly;
  logic               w_lx_in;
  logic               w_ly_in;
  logic               w_hit1;
  logic               w_mask;
  logic               w_on_next;
  logic [7:0]         w_rgb_next;

  // Position latch: only frame_start may move the cloud
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_lat <= 10'(SCREEN_W + CLOUD_W);
      r_v_lat <= 10'(200 - CLOUD_H);
    end else if (frame_start) begin
      r_h_lat <= cloud_h;
      r_v_lat <= cloud_v;
    end
  end

  // Stage 1: cloud-local coordinates; negative x_left clips at column 0
  assign w_x_left = $signed({1'b0, r_h_lat}) - $signed(11'(CLOUD_W));
  assign w_lx     = $signed({1'b0, hc}) - w_x_left;
  assign w_ly     = $signed({1'b0, vc}) - $signed({1'b0, r_v_lat});
  assign w_lx_in  = !w_lx[10] && (w_lx[9:0] < 10'(CLOUD_W));
  assign w_ly_in  = !w_ly[10] && (w_ly[9:0] < 10'(CLOUD_H));
  assign w_hit1   = de && w_lx_in && w_ly_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit1 <= 1'b0;
      r_lx   <= 7'd0;
      r_ly   <= 5'd0;
    end else if (pix_en) begin
      r_hit1 <= w_hit1;
      r_lx   <= w_lx[6:0];
      r_ly   <= w_ly[4:0];
    end
  end

  // Stage 2: shape mask and colour
`ifdef CLOUD_SHADOW_EN
  logic w_shade;

  cloud_shape u_shape (
    .i_lx      (r_lx),
    .i_ly      (r_ly),
    .o_mask_c  (w_mask),
    .o_shade_c (w_shade)
  );

  assign w_on_next  = r_hit1 && w_mask;
  assign w_rgb_next = !w_on_next ? dino_pkg::COL_BLACK :
                      (w_shade ? dino_pkg::COL_SHADE : CLOUD_RGB);

  always_ff @(posedge clk) begin
    if (rst) begin
      cloud_shade <= 1'b0;
    end else if (pix_en) begin
      cloud_shade <= w_on_next && w_shade;
    end
  end
`else
  cloud_shape u_shape (
    .i_lx     (r_lx),
    .i_ly     (r_ly),
    .o_mask_c (w_mask)
  );

  assign w_on_next  = r_hit1 && w_mask;
  assign w_rgb_next = w_on_next ? CLOUD_RGB : dino_pkg::COL_BLACK;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cloud_on  <= 1'b0;
      cloud_rgb <= 8'd0;
    end else if (pix_en) begin
      cloud_on  <= w_on_next;
      cloud_rgb <= w_rgb_next;
    end
  end

endmodule

// File: tb/tb_cloud_sprite_render.sv
// Scoreboard bench for cloud_sprite_render.
module tb_cloud_sprite_render;

  logic       clk;
  logic       rst;
  logic       pix_en;
  logic       frame_start;
  logic       de;
  logic [9:0] hc;
  logic [9:0] vc;
  logic [9:0] cloud_h;
  logic [9:0] cloud_v;
  logic       cloud_on;
  logic [7:0] cloud_rgb;
`ifdef CLOUD_SHADOW_EN
  logic       cloud_shade;
`endif

  cloud_sprite_render dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .frame_start (frame_start),
    .de          (de),
    .hc          (hc),
    .vc          (vc),
    .cloud_h     (cloud_h),
    .cloud_v     (cloud_v),
    .cloud_on    (cloud_on),
    .cloud_rgb   (cloud_rgb)
`ifdef CLOUD_SHADOW_EN
    ,
    .cloud_shade (cloud_shade)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the latched position
  int m_h;
  int m_v;

  // Scoreboard: expected {shade, on, rgb} per strobed pixel
  logic [9:0] q_exp[$];
  string      q_tag[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model written directly from the cloud geometry
  function automatic logic [9:0] model(input int x, input int y, input logic en,
                                       input int h, input int v);
    int  lx;
    int  ly;
    logic on;
    logic sh;
    lx = x - (h - 80);
    ly = y - v;
    on = 1'b0;
    if (en && lx >= 0 && lx < 80 && ly >= 0 && ly < 30) begin
      if (ly < 10)
        on = (lx >= 20 && lx <= 59);
      else if (ly >= 26 && (lx <= 3 || lx >= 76))
        on = 1'b0;
      else
        on = 1'b1;
    end
`ifdef CLOUD_SHADOW_EN
    sh = on && (ly >= 24);
    return {sh, on, on ? (sh ? 8'hB6 : 8'hFF) : 8'h00};
`else
    sh = 1'b0;
    return {sh, on, on ? 8'hFF : 8'h00};
`endif
  endfunction

  task automatic compare_front();
    logic [9:0] e;
    string      t;
    e = q_exp.pop_front();
    t = q_tag.pop_front();
    check({t, ".on"}, 32'(cloud_on), 32'(e[8]));
    check({t, ".rgb"}, 32'(cloud_rgb), 32'(e[7:0]));
`ifdef CLOUD_SHADOW_EN
    check({t, ".shade"}, 32'(cloud_shade), 32'(e[9]));
`endif
  endtask

  // One pixel strobe; optionally pulses frame_start in the same clock
  task automatic strobe(input string tag, input int x, input int y, input logic en,
                        input logic fs, input int nh, input int nv);
    hc     = 10'(x);
    vc     = 10'(y);
    de     = en;
    pix_en = 1'b1;
    if (fs) begin
      frame_start = 1'b1;
      cloud_h     = 10'(nh);
      cloud_v     = 10'(nv);
    end
    q_exp.push_back(model(x, y, en, m_h, m_v));
    q_tag.push_back(tag);
    @(posedge clk);
    #1;
    if (fs) begin
      m_h = nh;
      m_v = nv;
    end
    frame_start = 1'b0;
    pix_en      = 1'b0;
    if (q_exp.size() >= 2) compare_front();
  endtask

  task automatic pix(input string tag, input int x, input int y);
    strobe(tag, x, y, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic bubble();
    strobe("bubble", 0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  // Frame latch with the pipeline held
  task automatic latch(input int h, input int v);
    cloud_h     = 10'(h);
    cloud_v     = 10'(v);
    frame_start = 1'b1;
    pix_en      = 1'b0;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    m_h = h;
    m_v = v;
  endtask

  task automatic idle();
    pix_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; frame_start = 1'b0; de = 1'b0;
    hc = '0; vc = '0; cloud_h = '0; cloud_v = '0;
    m_h = 720; m_v = 170;
    repeat (2) @(posedge clk);
    #1;
    check("reset.on", 32'(cloud_on), 32'd0);
    check("reset.rgb", 32'(cloud_rgb), 32'd0);
    rst = 1'b0;

    // Reset position: cloud sits just right of the visible area
    pix("rstpos_680", 680, 180);
    bubble();

    // Basic edges
    latch(400, 170);
    pix("basic_320", 320, 180);
    pix("basic_319", 319, 180);
    pix("basic_399", 399, 180);
    pix("basic_400", 400, 180);
    // Shape rows
    pix("top_330", 330, 170);
    pix("top_340", 340, 170);
    pix("top_379", 379, 170);
    pix("top_380", 380, 170);
    pix("bot_321", 321, 199);
    pix("bot_324", 324, 199);
    pix("bot_398", 398, 199);
    pix("bot_396", 396, 199);
    pix("row9_339", 339, 179);
    pix("row10_320", 320, 180);
    pix("vc_169", 340, 169);
    pix("vc_200", 340, 200);
    strobe("de0", 340, 185, 1'b0, 1'b0, 0, 0);
    bubble();

    // Left clip
    latch(30, 170);
    pix("clip_0", 0, 185);
    pix("clip_29", 29, 185);
    pix("clip_30", 30, 185);
    bubble();

    // Fully off-screen left
    latch(0, 170);
    for (int y = 170; y < 200; y += 7)
      for (int x = 0; x < 640; x += 9)
        pix("off_left", x, y);
    bubble();

    // Frame latch: input changes ignored without frame_start
    latch(400, 170);
    cloud_h = 10'd200;
    pix("nolatch_320", 320, 180);
    latch(200, 170);
    pix("latched_320", 320, 180);
    pix("latched_120", 120, 180);
    // frame_start in the same clock as a pixel: old position applies
    strobe("same_clk_120", 120, 180, 1'b1, 1'b1, 400, 170);
    pix("after_120", 120, 180);
    pix("after_320", 320, 180);

    // Hold with pix_en low
    pix("hold_hit", 350, 185);
    bubble();
    for (int i = 0; i < 5; i++) begin
      idle();
      check("hold.on", 32'(cloud_on), 32'd1);
      check("hold.rgb", 32'(cloud_rgb), 32'hFF);
    end
    bubble();

    // Reset mid-frame with a hit in flight
    pix("prerst_hit", 350, 185);
    hc = 10'd350; vc = 10'd185; de = 1'b1; pix_en = 1'b1; frame_start = 1'b1;
    cloud_h = 10'd500; cloud_v = 10'd100;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; pix_en = 1'b0; frame_start = 1'b0;
    check("midrst.on", 32'(cloud_on), 32'd0);
    check("midrst.rgb", 32'(cloud_rgb), 32'd0);
    q_exp.delete();
    q_tag.delete();
    m_h = 720; m_v = 170;
    pix("postrst_680", 680, 180);
    strobe("postrst_de0", 680, 180, 1'b0, 1'b0, 0, 0);
    pix("postrst_350", 350, 185);
    bubble();

`ifdef CLOUD_SHADOW_EN
    latch(400, 170);
    pix("shadow_195", 350, 195);
    pix("shadow_185", 350, 185);
    bubble();
`endif

    // Randomised sweeps around several positions, with held strobes
    for (int p = 0; p < 4; p++) begin
      int h;
      int v;
      h = $urandom_range(40, 700);
      v = $urandom_range(100, 300);
      latch(h, v);
      for (int i = 0; i < 120; i++) begin
        int x;
        int y;
        x = h - 90 + int'($urandom_range(0, 100));
        y = v - 3 + int'($urandom_range(0, 35));
        if (x < 0) x = 0;
        if ($urandom_range(0, 3) == 0) idle();
        strobe("rand", x, y, ($urandom_range(0, 4) != 0), 1'b0, 0, 0);
      end
      bubble();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
